// File: rtl/ram_sp_pkg.sv
// ram_sp_pkg: state encodings and bus width defaults shared by the RAM controller and RAM.
package ram_sp_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4
    } state_e;
endpackage

// File: rtl/ram_sp_req_ctrl.sv
// ram_sp_req_ctrl: valid/ready command bridge sequencing a single-port synchronous RAM.
module ram_sp_req_ctrl
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  cs_q, we_q, oe_q, ready_q, valid_q;
    // Next state: the write/read choice is made at accept time, so the state itself carries req_we.
    always_comb begin
        state_d = (state_q == IDLE) ? (req_valid ? (req_we ? WR : RD1) : IDLE)
                : (state_q == RD1)  ? RD2
                : (state_q == RD2)  ? RESP
                : (state_q == RESP) ? (rsp_ready ? IDLE : RESP)
                : IDLE;
    end
    // FSM with registered strobes: outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_valid && ready_q) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == RD2) rdata_q <= ram_data;
            cs_q    <= (state_d == WR) || (state_d == RD1) || (state_d == RD2);
            we_q    <= state_d == WR;
            oe_q    <= (state_d == RD1) || (state_d == RD2);
            ready_q <= state_d == IDLE;
            valid_q <= state_d == RESP;
        end
    end
    // The bus is driven only in WR, where oe is low, so it never fights the RAM.
    assign ram_data    = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_address = addr_q;
    assign ram_cs      = cs_q;
    assign ram_we      = we_q;
    assign ram_oe      = oe_q;
    assign req_ready   = ready_q;
    assign rsp_valid   = valid_q;
    assign rsp_rdata   = rdata_q;
endmodule
